// File: rtl/mem_port_ctrl_pkg.sv
// mem_port_ctrl_pkg: regfile mode encodings, FSM states and default widths for mem_port_ctrl
package mem_port_ctrl_pkg;
  localparam int AW_DEF = 3;
  localparam int DW_DEF = 8;
  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_READ  = 2'b01;
  localparam logic [1:0] MODE_WRITE = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_CAPTURE, S_RESP} state_t;
endpackage

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: single-outstanding request sequencer in front of the regfile; MEM_PORT_BURST_EN enables req_len bursts
module mem_port_ctrl
  import mem_port_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
`ifdef MEM_PORT_BURST_EN
  input  logic [2:0]    req_len,
`endif
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_write,
  output logic [DW-1:0] rsp_rdata,
  output logic [1:0]    mem_mode,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
`ifndef MEM_PORT_BURST_EN
  logic [2:0] req_len;
  assign req_len = '0;
`endif
  state_t        state_q, state_d;
  logic          write_q, write_d;
  logic [2:0]    len_q, len_d;
  logic [1:0]    mem_mode_q, mem_mode_d;
  logic [AW-1:0] mem_address_q, mem_address_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_write_q, rsp_write_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  // mem_address_q/mem_wdata_q double as the latched request address and data
  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    len_d         = len_q;
    mem_mode_d    = MODE_IDLE;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_write_d   = rsp_write_q;
    rsp_rdata_d   = rsp_rdata_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        state_d       = S_ACCESS;
        write_d       = req_write;
        len_d         = req_len;
        mem_mode_d    = req_write ? MODE_WRITE : MODE_READ;
        mem_address_d = req_addr;
        mem_wdata_d   = req_wdata;
      end
      S_ACCESS: begin
        state_d     = write_q ? S_RESP : S_CAPTURE;
        rsp_valid_d = write_q;
        rsp_write_d = write_q;
        rsp_rdata_d = '0;
      end
      S_CAPTURE: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = mem_rdata;
      end
      S_RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = (len_q != 3'd0) ? S_ACCESS : S_IDLE;
        if (len_q != 3'd0) begin
          len_d         = len_q - 3'd1;
          mem_mode_d    = write_q ? MODE_WRITE : MODE_READ;
          mem_address_d = mem_address_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      write_q       <= 1'b0;
      len_q         <= '0;
      mem_mode_q    <= MODE_IDLE;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      len_q         <= len_d;
      mem_mode_q    <= mem_mode_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_write_q   <= rsp_write_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end
  assign req_ready   = (state_q == S_IDLE);
  assign mem_mode    = mem_mode_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_write   = rsp_write_q;
  assign rsp_rdata   = rsp_rdata_q;
endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb_mem_port_ctrl: directed bench for mem_port_ctrl with a behavioural regfile; burst sequence only under MEM_PORT_BURST_EN
module tb_mem_port_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_write;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;
  logic [2:0] req_len;
  logic       rsp_valid, rsp_ready, rsp_write;
  logic [7:0] rsp_rdata;
  logic [1:0] mem_mode;
  logic [2:0] mem_address;
  logic [7:0] mem_wdata, mem_rdata;
  logic [7:0] mem [8];
  int         wr_cnt = 0;
  int         cyc = 0;
  int         n_pass = 0;
  int         n_tot = 0;

  typedef struct {
    logic       w;
    logic [2:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[8];

  mem_port_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef MEM_PORT_BURST_EN
    .req_len(req_len),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .mem_mode(mem_mode), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // regfile: write on mode 10, registered read data on mode 01
  always @(posedge clk) begin
    if (mem_mode == 2'b10) begin
      mem[mem_address] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_mode == 2'b01) mem_rdata <= mem[mem_address];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // edges counted from acceptance E0: ack visible after E0+1 (write) or E0+2 (read)
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!rsp_valid && lat < 16);
  endtask

  task automatic xfer(input logic w, input logic [2:0] a, input logic [7:0] d,
                      input logic [7:0] exp, output int e0);
    int lat;
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    chk("req_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    e0 = cyc;
    chk("mem_mode", mem_mode, w ? 2'b10 : 2'b01);
    chk("mem_address", mem_address, a);
    if (w) chk("mem_wdata", mem_wdata, d);
    chk("req_ready_busy", req_ready, 0);
    wait_rsp(lat);
    chk("rsp_latency", lat, w ? 1 : 2);
    chk("rsp_write", rsp_write, w);
    chk("rsp_rdata", rsp_rdata, exp);
    @(posedge clk); #1;
    chk("rsp_done", rsp_valid, 0);
    chk("req_ready_after", req_ready, 1);
  endtask

  initial begin
    int e0, prev_e0, lat, wc0, extra;
    logic [7:0] bexp [4];
    logic [2:0] ea;
    vecs[0] = '{1'b1, 3'd2, 8'h34, 8'h00};
    vecs[1] = '{1'b0, 3'd2, 8'h00, 8'h34};
    vecs[2] = '{1'b1, 3'd0, 8'h31, 8'h00};
    vecs[3] = '{1'b1, 3'd1, 8'h35, 8'h00};
    vecs[4] = '{1'b0, 3'd0, 8'h00, 8'h31};
    vecs[5] = '{1'b0, 3'd1, 8'h00, 8'h35};
    vecs[6] = '{1'b1, 3'd7, 8'hA5, 8'h00};
    vecs[7] = '{1'b0, 3'd7, 8'h00, 8'hA5};
    bexp = '{8'h16, 8'h17, 8'h10, 8'h11};
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_len = '0; rsp_ready = 1'b1;
    #2;
    chk("rst_mem_mode", mem_mode, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_req_ready", req_ready, 1);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // reset during the ACCESS cycle of a write
    wc0 = wr_cnt;
    req_write = 1'b1; req_addr = 3'd4; req_wdata = 8'h77; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_pre_mode", mem_mode, 2'b10);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_mem_mode", mem_mode, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_mem_address", mem_address, 0);
    chk("abort_mem_wdata", mem_wdata, 0);
    #10 rst_n = 1'b1;
    #1 chk("abort_req_ready", req_ready, 1);
    @(posedge clk); #1;
    repeat (3) begin
      chk("abort_no_rsp", rsp_valid, 0);
      @(posedge clk); #1;
    end
    chk("abort_no_write", wr_cnt, wc0);

    // single-beat table with back-to-back throughput
    prev_e0 = 0;
    for (int i = 0; i < 8; i++) begin
      xfer(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp, e0);
      if (i > 0) chk("accept_gap", e0 - prev_e0, vecs[i-1].w ? 3 : 4);
      prev_e0 = e0;
    end

    // read stalled by rsp_ready low while the next request waits
    rsp_ready = 1'b0;
    req_write = 1'b0; req_addr = 3'd2; req_valid = 1'b1;
    @(posedge clk); #1;
    req_write = 1'b1; req_addr = 3'd3; req_wdata = 8'h5A;
    wait_rsp(lat);
    chk("stall_latency", lat, 2);
    chk("stall_rdata", rsp_rdata, 8'h34);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("stall_valid", rsp_valid, 1);
      chk("stall_rdata_hold", rsp_rdata, 8'h34);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_mem_idle", mem_mode, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_released", rsp_valid, 0);
    chk("stall_ready_back", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("post_stall_mode", mem_mode, 2'b10);
    chk("post_stall_addr", mem_address, 3'd3);
    wait_rsp(lat);
    chk("post_stall_ack", rsp_write, 1);
    @(posedge clk); #1;

`ifdef MEM_PORT_BURST_EN
    // read burst from addr 6, len 3: wraps through 7, 0, 1
    xfer(1'b1, 3'd6, 8'h16, 8'h00, e0);
    xfer(1'b1, 3'd7, 8'h17, 8'h00, e0);
    xfer(1'b1, 3'd0, 8'h10, 8'h00, e0);
    xfer(1'b1, 3'd1, 8'h11, 8'h00, e0);
    req_write = 1'b0; req_addr = 3'd6; req_len = 3'd3; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_len = 3'd0;
    for (int i = 0; i < 4; i++) begin
      ea = 3'd6 + 3'(i);
      chk("burst_mode", mem_mode, 2'b01);
      chk("burst_addr", mem_address, ea);
      wait_rsp(lat);
      chk("burst_latency", lat, 2);
      chk("burst_rdata", rsp_rdata, bexp[i]);
      @(posedge clk); #1;
    end
    chk("burst_ready", req_ready, 1);
    extra = 0;
    repeat (6) begin
      if (rsp_valid) extra++;
      @(posedge clk); #1;
    end
    chk("burst_extra_rsp", extra, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
